seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Bus-mapped sequencer that runs repeated, ordered acquisitions on a `seq_gen`/`seq_rec` pair.
- Per iteration: issues a start pulse to the generator, waits a programmable delay, issues a start pulse to the recorder, then waits until both report completion.
- Repeats a programmed number of times, with a wait timeout and a completed-iteration counter.
- Sits on the 8-bit basil bus beside the pulse generator and drives the cores' `SEQ_EXT_START`-style inputs.

## Interface
- `BASEADDR`, 0: first bus address of the register window.
- `HIGHADDR`, 0: last bus address of the register window.
- `ABUSWIDTH`, 16: bus address width.
- `BUS_CLK` input 1: single clock for all logic.
- `BUS_RST` input 1: reset. Synchronous, active-low. All state clears on the first `BUS_CLK` edge with `BUS_RST`=0.
- `BUS_ADD` input ABUSWIDTH: bus address.
- `BUS_DATA` inout 8: bus data. Driven only while a read in the window is active, otherwise high-Z.
- `BUS_RD` input 1: read strobe.
- `BUS_WR` input 1: write strobe.
- `GEN_START` output 1: one-cycle start pulse to the generator.
- `REC_START` output 1: one-cycle start pulse to the recorder.
- `GEN_DONE` input 1: one-cycle pulse, generator finished.
- `REC_DONE` input 1: one-cycle pulse, recorder finished.
- `BUSY` output 1: high whenever the FSM is not in IDLE.

## Operation
Register map is offset from BASEADDR.
- 0: read VERSION = 1. Any write is a soft reset with the same effect as `BUS_RST`.
- 1: write any value = START. Ignored while BUSY.
- 2: write any value = STOP. Finishes the current WAIT, then goes to IDLE.
- 3: REC_DELAY[7:0], read/write.
- 4: REPEAT[7:0], read/write. Value 0 means run until STOP.
- 5: TIMEOUT[7:0], read/write. Wait limit is TIMEOUT×256 cycles; 0 disables the timeout.
- 6: read STATUS = {5'b0, TIMEOUT_FLAG, BUSY, DONE}.
- 7: read ITER_CNT[7:0].
- 8: read ITER_CNT[15:8].

FSM states:
- IDLE: on START, clear ITER_CNT, DONE and TIMEOUT_FLAG, then go to FIRE_GEN.
- FIRE_GEN: assert `GEN_START` for one cycle and clear both sticky done flags. If REC_DELAY=0, go to FIRE_REC; otherwise go to DELAY.
- DELAY: count REC_DELAY cycles, then go to FIRE_REC.
- FIRE_REC: assert `REC_START` for one cycle, then go to WAIT.
- WAIT: exit when both sticky flags are set. On exit, ITER_CNT increments (16-bit, saturates at 0xFFFF). Then:
  - if STOP is pending, or REPEAT≠0 and ITER_CNT equals REPEAT, go to IDLE and set DONE;
  - otherwise go to FIRE_GEN.

Sticky done flags:
- `GEN_DONE` and `REC_DONE` set their flags in any non-IDLE state, including DELAY and FIRE_REC.
- A done pulse in the same cycle as FIRE_GEN is discarded, because clearing has priority.

Timeout:
- A 16-bit wait counter runs only in WAIT.
- When it reaches TIMEOUT×256, go to IDLE with TIMEOUT_FLAG set, DONE clear and ITER_CNT unchanged.

STOP:
- Outside WAIT, a pending STOP takes effect at the next WAIT exit.
- STOP in IDLE is ignored.

Configuration writes while BUSY:
- A write to REC_DELAY, REPEAT or TIMEOUT updates the register immediately.
- The new value takes effect at the next comparison.

Reset:
- `BUS_RST` low, or a soft reset, mid-run forces IDLE.
- All registers go to 0; DONE, TIMEOUT_FLAG and ITER_CNT clear.
- No start pulse is emitted.

## Timing
- Reset values: `GEN_START`=0, `REC_START`=0, `BUSY`=0, `BUS_DATA` high-Z.
- START write at edge N: FIRE_GEN is entered at N+1; `GEN_START` is high in cycle N+1 and `BUSY` goes high at N+1.
- Start-pulse separation: rising edges of `GEN_START` and `REC_START` are exactly REC_DELAY+1 cycles apart (1 cycle when REC_DELAY=0).
- WAIT to next iteration: the cycle after both flags are set is FIRE_GEN (or IDLE at the end of the run).
- Minimum iteration period: REC_DELAY+3 cycles, given both done pulses arrive during FIRE_REC.
- Bus reads: data is registered and valid on the cycle after `BUS_RD`. Register writes take effect on the `BUS_WR` edge.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, FIRE_GEN, DELAY, FIRE_REC, WAIT;
  - register offset constants;
  - VERSION.
- Top level `seq_scan_ctrl` contains the bus decode and uses `bus_to_ip`.
- One sub-module, `seq_scan_ctrl_core`, holds the FSM, counters and sticky flags. Its interface is plain register-style strobes and data.

## Test plan
- Smoke run: REPEAT=3, REC_DELAY=4, dones returned 10 cycles after each start → three `GEN_START` and three `REC_START` pulses, each `REC_START` 5 cycles after its `GEN_START`; DONE=1, ITER_CNT=3, `BUSY` falls.
- Zero delay, early done: REC_DELAY=0, `GEN_DONE` pulsed during FIRE_REC, `REC_DONE` pulsed 2 cycles later → `REC_START` 1 cycle after `GEN_START`; iteration completes and the early flag is not lost.
- Timeout: TIMEOUT=1, `REC_DONE` never arrives → IDLE exactly 256 cycles after WAIT entry; STATUS=0x04, ITER_CNT=0.
- Continuous with STOP: REPEAT=0, STOP written during iteration 5's DELAY → iteration 5 completes, then IDLE with ITER_CNT=5, DONE=1 and no sixth `GEN_START`.
- Reset mid-run: `BUS_RST`=0 for 1 cycle during DELAY → all outputs 0, registers read 0; a subsequent START with REPEAT=1 runs normally.
- Collision and re-START: `GEN_DONE` coincident with FIRE_GEN is ignored, so the run stays in WAIT until a later `GEN_DONE`. A START written while BUSY is ignored.

Source files
------------

// File: rtl/seq_scan_ctrl_pkg.sv
// rtl/seq_scan_ctrl_pkg.sv - shared FSM encoding, register offsets and version for the scan sequencer
package seq_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRE_GEN = 3'd1,
        ST_DELAY    = 3'd2,
        ST_FIRE_REC = 3'd3,
        ST_WAIT     = 3'd4
    } scan_state_t;

    // Register offsets from the window base
    localparam logic [3:0] REG_VERSION   = 4'd0;
    localparam logic [3:0] REG_START     = 4'd1;
    localparam logic [3:0] REG_STOP      = 4'd2;
    localparam logic [3:0] REG_REC_DELAY = 4'd3;
    localparam logic [3:0] REG_REPEAT    = 4'd4;
    localparam logic [3:0] REG_TIMEOUT   = 4'd5;
    localparam logic [3:0] REG_STATUS    = 4'd6;
    localparam logic [3:0] REG_ITER_LO   = 4'd7;
    localparam logic [3:0] REG_ITER_HI   = 4'd8;

    localparam logic [7:0] VERSION = 8'd1;

endpackage

// File: rtl/bus_to_ip.sv
// rtl/bus_to_ip.sv - address window decode from the basil bus to a local register port
// Ports:
//   BUS_RD/BUS_WR/BUS_ADD/BUS_DATA : raw bus strobes, address and write data
//   IP_RD/IP_WR                    : strobes qualified by the address window
//   IP_ADD                         : address relative to BASEADDR
//   IP_DATA_IN                     : write data towards the register block
module bus_to_ip #(
    parameter int BASEADDR  = 0,
    parameter int HIGHADDR  = 0,
    parameter int ABUSWIDTH = 16,
    parameter int DBUSWIDTH = 8
) (
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [DBUSWIDTH-1:0] BUS_DATA,
    output logic                 IP_RD,
    output logic                 IP_WR,
    output logic [ABUSWIDTH-1:0] IP_ADD,
    output logic [DBUSWIDTH-1:0] IP_DATA_IN
);
    localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);
    localparam logic [ABUSWIDTH-1:0] SPAN = ABUSWIDTH'(HIGHADDR - BASEADDR);

    logic w_cs;

    // Offset-then-compare keeps the window check a single unsigned test
    assign IP_ADD     = BUS_ADD - BASE;
    assign w_cs       = (IP_ADD <= SPAN);
    assign IP_RD      = BUS_RD && w_cs;
    assign IP_WR      = BUS_WR && w_cs;
    assign IP_DATA_IN = BUS_DATA;

endmodule

// File: rtl/seq_scan_ctrl_core.sv
// rtl/seq_scan_ctrl_core.sv - generator/recorder sequencing FSM with counters and sticky done flags
// Ports:
//   i_clk, i_resetn      : clock, synchronous active-low reset
//   i_soft_rst           : one-cycle strobe with the same effect as reset
//   i_start, i_stop      : one-cycle command strobes from the register block
//   i_rec_delay/i_repeat/i_timeout : live configuration values
//   i_gen_done/i_rec_done: completion pulses from the cores
//   o_gen_start/o_rec_start : one-cycle start pulses to the cores
//   o_busy, o_done, o_timeout_flag, o_iter_cnt : status
module seq_scan_ctrl_core
    import seq_scan_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_soft_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [7:0]  i_rec_delay,
    input  logic [7:0]  i_repeat,
    input  logic [7:0]  i_timeout,
    input  logic        i_gen_done,
    input  logic        i_rec_done,
    output logic        o_gen_start,
    output logic        o_rec_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout_flag,
    output logic [15:0] o_iter_cnt
);
    scan_state_t r_state;
    scan_state_t w_state_next;

    logic        r_gen_flag;
    logic        r_rec_flag;
    logic        r_stop_pend;
    logic        r_done;
    logic        r_timeout_flag;
    logic [7:0]  r_dly_cnt;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_iter_cnt;

    logic        w_clr;
    logic        w_both;
    logic        w_stop_now;
    logic        w_last;
    logic        w_dly_end;
    logic        w_timeout;
    logic [15:0] w_iter_inc;

    assign w_clr      = !i_resetn || i_soft_rst;
    assign w_both     = r_gen_flag && r_rec_flag;
    assign w_iter_inc = (r_iter_cnt == 16'hFFFF) ? r_iter_cnt : r_iter_cnt + 16'd1;
    // A STOP landing in the exit cycle itself still ends the run
    assign w_stop_now = r_stop_pend || i_stop;
    assign w_last     = w_stop_now ||
                        ((i_repeat != 8'd0) && (w_iter_inc == {8'd0, i_repeat}));
    // >= rather than == so a shrinking REC_DELAY/TIMEOUT mid-run cannot strand the FSM
    assign w_dly_end  = ({1'b0, r_dly_cnt} + 9'd1) >= {1'b0, i_rec_delay};
    assign w_timeout  = (i_timeout != 8'd0) &&
                        (({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, i_timeout, 8'd0});

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (i_start) w_state_next = ST_FIRE_GEN;
            ST_FIRE_GEN: w_state_next = (i_rec_delay == 8'd0) ? ST_FIRE_REC : ST_DELAY;
            ST_DELAY:    if (w_dly_end) w_state_next = ST_FIRE_REC;
            ST_FIRE_REC: w_state_next = ST_WAIT;
            ST_WAIT: begin
                // Completion wins over a simultaneous timeout
                if (w_both) begin
                    w_state_next = w_last ? ST_IDLE : ST_FIRE_GEN;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_gen_start = (r_state == ST_FIRE_GEN);
        o_rec_start = (r_state == ST_FIRE_REC);
        o_busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_gen_flag     <= 1'b0;
            r_rec_flag     <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_dly_cnt      <= 8'd0;
            r_wait_cnt     <= 16'd0;
            r_iter_cnt     <= 16'd0;
        end else begin
            r_dly_cnt  <= (r_state == ST_DELAY) ? r_dly_cnt + 8'd1 : 8'd0;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;

            // Clearing in FIRE_GEN has priority, so a done pulse colliding with it is dropped
            if (r_state == ST_FIRE_GEN) begin
                r_gen_flag <= 1'b0;
                r_rec_flag <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (i_gen_done) r_gen_flag <= 1'b1;
                if (i_rec_done) r_rec_flag <= 1'b1;
            end

            if (i_stop && (r_state != ST_IDLE)) r_stop_pend <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_iter_cnt     <= 16'd0;
                        r_done         <= 1'b0;
                        r_timeout_flag <= 1'b0;
                        r_stop_pend    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_both) begin
                        r_iter_cnt <= w_iter_inc;
                        if (w_last) begin
                            r_done      <= 1'b1;
                            r_stop_pend <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_timeout_flag <= 1'b1;
                        r_stop_pend    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done         = r_done;
    assign o_timeout_flag = r_timeout_flag;
    assign o_iter_cnt     = r_iter_cnt;

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - bus-mapped sequencer driving a seq_gen/seq_rec pair
// Ports:
//   BUS_CLK, BUS_RST      : clock, synchronous active-low reset
//   BUS_ADD/BUS_DATA/BUS_RD/BUS_WR : basil 8-bit bus; reads return data the cycle after BUS_RD
//   GEN_START, REC_START  : one-cycle start pulses to the generator and recorder
//   GEN_DONE, REC_DONE    : one-cycle completion pulses from the cores
//   BUSY                  : sequencer is running
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int BASEADDR  = 0,
    parameter int HIGHADDR  = 0,
    parameter int ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic                 GEN_START,
    output logic                 REC_START,
    input  logic                 GEN_DONE,
    input  logic                 REC_DONE,
    output logic                 BUSY
);
    logic                 w_ip_rd;
    logic                 w_ip_wr;
    logic [ABUSWIDTH-1:0] w_ip_add;
    logic [7:0]           w_ip_wdata;
    logic [3:0]           w_off;
    logic                 w_in_map;
    logic                 w_wr;
    logic                 w_soft_rst;
    logic                 w_start;
    logic                 w_stop;
    logic [7:0]           w_rd_mux;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_timeout_flag;
    logic [15:0]          w_iter_cnt;

    logic [7:0]           r_rec_delay;
    logic [7:0]           r_repeat;
    logic [7:0]           r_timeout;
    logic [7:0]           r_rd_data;
    logic                 r_rd_valid;

    bus_to_ip #(
        .BASEADDR  (BASEADDR),
        .HIGHADDR  (HIGHADDR),
        .ABUSWIDTH (ABUSWIDTH),
        .DBUSWIDTH (8)
    ) u_bus_to_ip (
        .BUS_RD     (BUS_RD),
        .BUS_WR     (BUS_WR),
        .BUS_ADD    (BUS_ADD),
        .BUS_DATA   (BUS_DATA),
        .IP_RD      (w_ip_rd),
        .IP_WR      (w_ip_wr),
        .IP_ADD     (w_ip_add),
        .IP_DATA_IN (w_ip_wdata)
    );

    // Only offsets 0..15 decode; anything beyond in a wider window is inert
    assign w_off      = w_ip_add[3:0];
    assign w_in_map   = (w_ip_add[ABUSWIDTH-1:4] == '0);
    assign w_wr       = w_ip_wr && w_in_map;
    assign w_soft_rst = w_wr && (w_off == REG_VERSION);
    assign w_start    = w_wr && (w_off == REG_START);
    assign w_stop     = w_wr && (w_off == REG_STOP);

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST || w_soft_rst) begin
            r_rec_delay <= 8'd0;
            r_repeat    <= 8'd0;
            r_timeout   <= 8'd0;
        end else if (w_wr) begin
            case (w_off)
                REG_REC_DELAY: r_rec_delay <= w_ip_wdata;
                REG_REPEAT:    r_repeat    <= w_ip_wdata;
                REG_TIMEOUT:   r_timeout   <= w_ip_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_off)
            REG_VERSION:   w_rd_mux = VERSION;
            REG_REC_DELAY: w_rd_mux = r_rec_delay;
            REG_REPEAT:    w_rd_mux = r_repeat;
            REG_TIMEOUT:   w_rd_mux = r_timeout;
            REG_STATUS:    w_rd_mux = {5'b0, w_timeout_flag, w_busy, w_done};
            REG_ITER_LO:   w_rd_mux = w_iter_cnt[7:0];
            REG_ITER_HI:   w_rd_mux = w_iter_cnt[15:8];
            default: ;
        endcase
        if (!w_in_map) w_rd_mux = 8'h00;
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_rd_valid <= w_ip_rd;
            r_rd_data  <= w_rd_mux;
        end
    end

    // The bus is only driven in the cycle the registered read data is valid
    assign BUS_DATA = r_rd_valid ? r_rd_data : 8'hzz;

    seq_scan_ctrl_core u_core (
        .i_clk          (BUS_CLK),
        .i_resetn       (BUS_RST),
        .i_soft_rst     (w_soft_rst),
        .i_start        (w_start),
        .i_stop         (w_stop),
        .i_rec_delay    (r_rec_delay),
        .i_repeat       (r_repeat),
        .i_timeout      (r_timeout),
        .i_gen_done     (GEN_DONE),
        .i_rec_done     (REC_DONE),
        .o_gen_start    (GEN_START),
        .o_rec_start    (REC_START),
        .o_busy         (w_busy),
        .o_done         (w_done),
        .o_timeout_flag (w_timeout_flag),
        .o_iter_cnt     (w_iter_cnt)
    );

    assign BUSY = w_busy;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;
    import seq_scan_ctrl_pkg::*;

    localparam int BASE = 'h0100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] add;
    logic        rd;
    logic        wr;
    logic [7:0]  tb_wdata;
    logic        tb_drv;
    wire  [7:0]  bus_data;
    logic        gen_start;
    logic        rec_start;
    logic        busy;
    logic        man_gen;
    logic        man_rec;
    logic        auto_gen = 1'b0;
    logic        auto_rec = 1'b0;
    wire         gen_done = man_gen | auto_gen;
    wire         rec_done = man_rec | auto_rec;

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    seq_scan_ctrl #(
        .BASEADDR  ('h0100),
        .HIGHADDR  ('h010F),
        .ABUSWIDTH (16)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST   (rst_n),
        .BUS_ADD   (add),
        .BUS_DATA  (bus_data),
        .BUS_RD    (rd),
        .BUS_WR    (wr),
        .GEN_START (gen_start),
        .REC_START (rec_start),
        .GEN_DONE  (gen_done),
        .REC_DONE  (rec_done),
        .BUSY      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor and automatic done responder
    int   n_gen = 0;
    int   n_rec = 0;
    int   sep_bad = 0;
    int   last_gen = 0;
    int   gen_due = -1;
    int   rec_due = -1;
    logic auto_en = 1'b0;
    int   lat = 10;
    int   exp_sep = 1;

    always @(negedge clk) begin
        if (gen_start) begin
            n_gen++;
            last_gen = cyc;
            if (auto_en) gen_due = cyc + lat;
        end
        if (rec_start) begin
            n_rec++;
            if (cyc - last_gen != exp_sep) sep_bad++;
            if (auto_en) rec_due = cyc + lat;
        end
        auto_gen = auto_en && (cyc == gen_due);
        auto_rec = auto_en && (cyc == rec_due);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [7:0] d);
        add = 16'(BASE + int'(off));
        tb_wdata = d;
        tb_drv = 1'b1;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] off, output logic [7:0] d);
        add = 16'(BASE + int'(off));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        d = bus_data;
        tick();
    endtask

    task automatic rd_check(input string name, input logic [3:0] off, input int exp);
        logic [7:0] d;
        bus_rd(off, d);
        check(name, int'(d), exp);
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] off;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[18];
    int   b_gen;
    int   b_rec;
    int   b_sep;
    int   k;
    int   guard;

    initial begin
        rst_n = 1'b0; add = '0; rd = 1'b0; wr = 1'b0;
        tb_wdata = '0; tb_drv = 1'b0; man_gen = 1'b0; man_rec = 1'b0;

        tbl[0]  = '{1'b0, REG_VERSION,   8'h00, 8'h01};
        tbl[1]  = '{1'b0, REG_STATUS,    8'h00, 8'h00};
        tbl[2]  = '{1'b0, REG_ITER_LO,   8'h00, 8'h00};
        tbl[3]  = '{1'b0, REG_ITER_HI,   8'h00, 8'h00};
        tbl[4]  = '{1'b1, REG_REC_DELAY, 8'h5A, 8'h00};
        tbl[5]  = '{1'b1, REG_REPEAT,    8'hA5, 8'h00};
        tbl[6]  = '{1'b1, REG_TIMEOUT,   8'h3C, 8'h00};
        tbl[7]  = '{1'b1, REG_STATUS,    8'hFF, 8'h00};
        tbl[8]  = '{1'b0, REG_REC_DELAY, 8'h00, 8'h5A};
        tbl[9]  = '{1'b0, REG_REPEAT,    8'h00, 8'hA5};
        tbl[10] = '{1'b0, REG_TIMEOUT,   8'h00, 8'h3C};
        tbl[11] = '{1'b0, REG_STATUS,    8'h00, 8'h00};
        tbl[12] = '{1'b1, REG_VERSION,   8'h77, 8'h00};
        tbl[13] = '{1'b0, REG_REC_DELAY, 8'h00, 8'h00};
        tbl[14] = '{1'b0, REG_REPEAT,    8'h00, 8'h00};
        tbl[15] = '{1'b0, REG_TIMEOUT,   8'h00, 8'h00};
        tbl[16] = '{1'b1, REG_STOP,      8'h00, 8'h00};
        tbl[17] = '{1'b0, REG_STATUS,    8'h00, 8'h00};

        tick(3);
        check("rst_gen_start", int'(gen_start), 0);
        check("rst_rec_start", int'(rec_start), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Register access table
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                bus_wr(tbl[i].off, tbl[i].wdata);
            end else begin
                rd_check($sformatf("vec%0d", i), tbl[i].off, int'(tbl[i].exp));
            end
        end

        // Smoke: REPEAT=3, REC_DELAY=4, dones 10 cycles after each start
        exp_sep = 5; lat = 10; auto_en = 1'b1;
        b_gen = n_gen; b_rec = n_rec; b_sep = sep_bad;
        bus_wr(REG_REC_DELAY, 8'd4);
        bus_wr(REG_REPEAT, 8'd3);
        bus_wr(REG_START, 8'd0);
        check("smoke_gen_start_n1", int'(gen_start), 1);
        check("smoke_busy_n1", int'(busy), 1);
        wait_idle("smoke_idle", 200);
        auto_en = 1'b0;
        tick(2);
        check("smoke_gen_cnt", n_gen - b_gen, 3);
        check("smoke_rec_cnt", n_rec - b_rec, 3);
        check("smoke_sep", sep_bad - b_sep, 0);
        rd_check("smoke_status", REG_STATUS, 'h01);
        rd_check("smoke_iter_lo", REG_ITER_LO, 3);
        rd_check("smoke_iter_hi", REG_ITER_HI, 0);

        // Zero delay with early GEN_DONE during FIRE_REC
        exp_sep = 1;
        b_rec = n_rec; b_sep = sep_bad;
        bus_wr(REG_REC_DELAY, 8'd0);
        bus_wr(REG_REPEAT, 8'd1);
        bus_wr(REG_START, 8'd0);
        check("zd_gen_start", int'(gen_start), 1);
        tick();
        check("zd_rec_start", int'(rec_start), 1);
        check("zd_gen_low", int'(gen_start), 0);
        man_gen = 1'b1;
        tick();
        man_gen = 1'b0;
        check("zd_wait_busy", int'(busy), 1);
        tick();
        man_rec = 1'b1;
        tick();
        man_rec = 1'b0;
        check("zd_busy_before_exit", int'(busy), 1);
        tick();
        check("zd_idle", int'(busy), 0);
        check("zd_sep", sep_bad - b_sep, 0);
        check("zd_rec_cnt", n_rec - b_rec, 1);
        rd_check("zd_status", REG_STATUS, 'h01);
        rd_check("zd_iter_lo", REG_ITER_LO, 1);

        // Timeout: TIMEOUT=1, no done pulses at all
        bus_wr(REG_TIMEOUT, 8'd1);
        bus_wr(REG_START, 8'd0);
        tick();
        check("to_rec_start", int'(rec_start), 1);
        tick();
        tick(255);
        check("to_busy_last_wait", int'(busy), 1);
        tick();
        check("to_idle_at_256", int'(busy), 0);
        rd_check("to_status", REG_STATUS, 'h04);
        rd_check("to_iter_lo", REG_ITER_LO, 0);
        rd_check("to_iter_hi", REG_ITER_HI, 0);
        bus_wr(REG_TIMEOUT, 8'd0);

        // Continuous run, STOP during the fifth iteration's DELAY
        exp_sep = 5; lat = 1; auto_en = 1'b1;
        b_gen = n_gen; b_rec = n_rec; b_sep = sep_bad;
        bus_wr(REG_REPEAT, 8'd0);
        bus_wr(REG_REC_DELAY, 8'd4);
        bus_wr(REG_START, 8'd0);
        k = gen_start ? 1 : 0;
        guard = 0;
        while (k < 5 && guard < 200) begin
            tick();
            guard++;
            if (gen_start) k++;
        end
        check("cont_reach_iter5", k, 5);
        tick();
        bus_wr(REG_STOP, 8'd0);
        wait_idle("cont_idle", 100);
        auto_en = 1'b0;
        tick(5);
        check("cont_gen_cnt", n_gen - b_gen, 5);
        check("cont_rec_cnt", n_rec - b_rec, 5);
        check("cont_sep", sep_bad - b_sep, 0);
        rd_check("cont_status", REG_STATUS, 'h01);
        rd_check("cont_iter_lo", REG_ITER_LO, 5);

        // Reset pulse during DELAY
        b_rec = n_rec;
        bus_wr(REG_REC_DELAY, 8'd10);
        bus_wr(REG_REPEAT, 8'd2);
        bus_wr(REG_TIMEOUT, 8'd3);
        bus_wr(REG_START, 8'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_gen_start", int'(gen_start), 0);
        check("rr_rec_start", int'(rec_start), 0);
        check("rr_busy", int'(busy), 0);
        tick(12);
        check("rr_no_rec_pulse", n_rec - b_rec, 0);
        rd_check("rr_rec_delay", REG_REC_DELAY, 0);
        rd_check("rr_repeat", REG_REPEAT, 0);
        rd_check("rr_timeout", REG_TIMEOUT, 0);
        rd_check("rr_status", REG_STATUS, 0);
        rd_check("rr_iter_lo", REG_ITER_LO, 0);
        exp_sep = 3; lat = 3; auto_en = 1'b1;
        b_gen = n_gen; b_rec = n_rec; b_sep = sep_bad;
        bus_wr(REG_REPEAT, 8'd1);
        bus_wr(REG_REC_DELAY, 8'd2);
        bus_wr(REG_START, 8'd0);
        wait_idle("rr_run_idle", 100);
        auto_en = 1'b0;
        tick(2);
        check("rr_run_gen_cnt", n_gen - b_gen, 1);
        check("rr_run_rec_cnt", n_rec - b_rec, 1);
        check("rr_run_sep", sep_bad - b_sep, 0);
        rd_check("rr_run_status", REG_STATUS, 'h01);
        rd_check("rr_run_iter_lo", REG_ITER_LO, 1);

        // GEN_DONE colliding with FIRE_GEN is dropped; START while busy ignored
        exp_sep = 1;
        b_gen = n_gen; b_rec = n_rec;
        bus_wr(REG_REC_DELAY, 8'd0);
        bus_wr(REG_START, 8'd0);
        man_gen = 1'b1;
        tick();
        man_gen = 1'b0;
        man_rec = 1'b1;
        tick();
        man_rec = 1'b0;
        bus_wr(REG_START, 8'd0);
        tick(5);
        check("col_still_waiting", int'(busy), 1);
        check("col_no_restart", n_gen - b_gen, 1);
        man_gen = 1'b1;
        tick();
        man_gen = 1'b0;
        wait_idle("col_idle", 10);
        check("col_rec_cnt", n_rec - b_rec, 1);
        rd_check("col_status", REG_STATUS, 'h01);
        rd_check("col_iter_lo", REG_ITER_LO, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
